// File: rtl/rate_enable_gen_pkg.sv
// Shared types and reload arithmetic for the rate enable generator.
// Optional single-step feature is controlled by RATE_GEN_STEP_EN.
package rate_gen_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    localparam logic [1:0] SPD_FAST    = 2'b00;
    localparam logic [1:0] SPD_1HZ     = 2'b01;
    localparam logic [1:0] SPD_HALF    = 2'b10;
    localparam logic [1:0] SPD_QUARTER = 2'b11;

    localparam int RELOAD_W = 32;

    // Returns R so that the pulse period is R+1 cycles; callers truncate to CNT_W.
    function automatic logic [RELOAD_W-1:0] reload_of(input logic [1:0] speed,
                                                      input int unsigned clk_hz);
        logic [RELOAD_W-1:0] hz;
        logic [RELOAD_W-1:0] r;
        hz = clk_hz;
        case (speed)
            SPD_FAST:    r = '0;
            SPD_1HZ:     r = hz - 32'd1;
            SPD_HALF:    r = (hz << 1) - 32'd1;
            default:     r = (hz << 2) - 32'd1;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/rate_enable_gen_if.sv
// Control and pulse signals between the board controls and the rate generator.
// Step is only present when RATE_GEN_STEP_EN is defined.
interface rate_enable_gen_if;
    logic       Run;
    logic [1:0] Speed;
`ifdef RATE_GEN_STEP_EN
    logic       Step;
`endif
    logic       Enable;

`ifdef RATE_GEN_STEP_EN
    modport master (output Run, output Speed, output Step, input Enable);
    modport slave  (input Run, input Speed, input Step, output Enable);
`else
    modport master (output Run, output Speed, input Enable);
    modport slave  (input Run, input Speed, output Enable);
`endif
endinterface

// File: rtl/rate_enable_gen.sv
// Programmable rate divider producing a registered one-cycle Enable pulse.
// Define RATE_GEN_STEP_EN to add the Step input and its rising-edge detector.
module rate_enable_gen
    import rate_gen_pkg::*;
#(
    parameter int unsigned CLK_HZ = 50_000_000,
    parameter int          CNT_W  = 28
) (
    input  logic             Clock,
    input  logic             Resetn,
    rate_enable_gen_if.slave bus
);

    state_t             r_state;
    state_t             w_state_next;
    logic [CNT_W-1:0]   r_cnt;
    logic [CNT_W-1:0]   w_cnt_next;
    logic [1:0]         r_spd_q;
    logic [1:0]         w_spd_next;
    logic               r_enable;
    logic               w_enable_next;
    logic               w_step_rise;
    logic [CNT_W-1:0]   w_reload_in;
    logic [CNT_W-1:0]   w_reload_q;

    assign w_reload_in = CNT_W'(reload_of(bus.Speed, CLK_HZ));
    assign w_reload_q  = CNT_W'(reload_of(r_spd_q, CLK_HZ));

`ifdef RATE_GEN_STEP_EN
    logic r_step_q;

    always_ff @(posedge Clock or negedge Resetn) begin
        if (!Resetn) begin
            r_step_q <= 1'b0;
        end else begin
            r_step_q <= bus.Step;
        end
    end

    assign w_step_rise = bus.Step & ~r_step_q;
`else
    assign w_step_rise = 1'b0;
`endif

    always_ff @(posedge Clock or negedge Resetn) begin
        if (!Resetn) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            IDLE:    w_state_next = bus.Run ? RUN : IDLE;
            RUN:     w_state_next = bus.Run ? RUN : IDLE;
            default: w_state_next = IDLE;
        endcase
    end

    // Priority in RUN: Run deassert, then speed change (phase restart), then terminal count.
    always_comb begin
        w_enable_next = 1'b0;
        w_cnt_next    = r_cnt;
        w_spd_next    = r_spd_q;
        case (r_state)
            IDLE: begin
                w_enable_next = w_step_rise;
                if (bus.Run) begin
                    w_cnt_next = w_reload_in;
                    w_spd_next = bus.Speed;
                end
            end
            RUN: begin
                if (!bus.Run) begin
                    w_enable_next = 1'b0;
                end else if (bus.Speed != r_spd_q) begin
                    w_cnt_next = w_reload_in;
                    w_spd_next = bus.Speed;
                end else if (r_cnt == '0) begin
                    w_enable_next = 1'b1;
                    w_cnt_next    = w_reload_q;
                end else begin
                    w_cnt_next = r_cnt - CNT_W'(1);
                end
            end
            default: begin
                w_enable_next = 1'b0;
            end
        endcase
    end

    always_ff @(posedge Clock or negedge Resetn) begin
        if (!Resetn) begin
            r_cnt    <= '0;
            r_spd_q  <= SPD_FAST;
            r_enable <= 1'b0;
        end else begin
            r_cnt    <= w_cnt_next;
            r_spd_q  <= w_spd_next;
            r_enable <= w_enable_next;
        end
    end

    assign bus.Enable = r_enable;

endmodule

// File: tb/tb_rate_enable_gen.sv
// Self-checking bench for rate_enable_gen with CLK_HZ=4 (R = 0/3/7/15).
// Step scenarios run only when RATE_GEN_STEP_EN is defined.
module tb_rate_enable_gen;
    import rate_gen_pkg::*;

    logic Clock;
    logic Resetn;
    int   n_tests;
    int   n_fail;
    bit   exp_q[$];

    rate_enable_gen_if u_if ();

    rate_enable_gen #(
        .CLK_HZ (4),
        .CNT_W  (5)
    ) u_dut (
        .Clock  (Clock),
        .Resetn (Resetn),
        .bus    (u_if)
    );

    initial begin
        Clock = 1'b0;
        forever #5 Clock = ~Clock;
    end

    task automatic test_reset();
        bit e;
        Resetn   = 1'b0;
        u_if.Run   = 1'b0;
        u_if.Speed = SPD_FAST;
`ifdef RATE_GEN_STEP_EN
        u_if.Step  = 1'b0;
`endif
        #1;
        n_tests++;
        if (u_if.Enable !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_initial: got %b expected 0", u_if.Enable);
        end
        u_if.Run = 1'b1;
        for (int k = 0; k < 4; k++) begin
            if (k == 3) begin
                Resetn   = 1'b1;
                u_if.Run = 1'b0;
            end
            exp_q.push_back(1'b0);
            @(posedge Clock); #1;
            e = exp_q.pop_front();
            n_tests++;
            if (u_if.Enable !== e) begin
                n_fail++;
                $display("FAIL reset edge %0d: got %b expected %b", k, u_if.Enable, e);
            end else begin
                $display("[TB] reset edge %0d en=%b ok", k, u_if.Enable);
            end
        end
    endtask

    task automatic test_rate_1hz();
        bit e;
        u_if.Speed = SPD_1HZ;
        for (int k = 0; k <= 14; k++) begin
            u_if.Run = (k < 14);
            exp_q.push_back((k > 0) && (k % 4 == 0) && (k < 14));
            @(posedge Clock); #1;
            e = exp_q.pop_front();
            n_tests++;
            if (u_if.Enable !== e) begin
                n_fail++;
                $display("FAIL rate_1hz edge %0d: got %b expected %b", k, u_if.Enable, e);
            end else begin
                $display("[TB] rate_1hz edge %0d en=%b ok", k, u_if.Enable);
            end
        end
    endtask

    task automatic test_fast();
        bit e;
        u_if.Speed = SPD_FAST;
        for (int k = 0; k <= 7; k++) begin
            u_if.Run = (k < 6);
            exp_q.push_back((k >= 1) && (k <= 5));
            @(posedge Clock); #1;
            e = exp_q.pop_front();
            n_tests++;
            if (u_if.Enable !== e) begin
                n_fail++;
                $display("FAIL fast edge %0d: got %b expected %b", k, u_if.Enable, e);
            end else begin
                $display("[TB] fast edge %0d en=%b ok", k, u_if.Enable);
            end
        end
    endtask

    task automatic test_speed_change();
        bit e;
        for (int k = 0; k <= 31; k++) begin
            u_if.Run   = (k < 31);
            u_if.Speed = (k < 5) ? SPD_QUARTER : SPD_HALF;
            exp_q.push_back((k == 13) || (k == 21) || (k == 29));
            @(posedge Clock); #1;
            e = exp_q.pop_front();
            n_tests++;
            if (u_if.Enable !== e) begin
                n_fail++;
                $display("FAIL speed_change edge %0d: got %b expected %b", k, u_if.Enable, e);
            end else begin
                $display("[TB] speed_change edge %0d en=%b ok", k, u_if.Enable);
            end
        end
    endtask

    task automatic test_run_fall_at_tc();
        bit e;
        u_if.Speed = SPD_1HZ;
        for (int k = 0; k <= 16; k++) begin
            u_if.Run = (k <= 3) || ((k >= 7) && (k <= 15));
            exp_q.push_back((k == 11) || (k == 15));
            @(posedge Clock); #1;
            e = exp_q.pop_front();
            n_tests++;
            if (u_if.Enable !== e) begin
                n_fail++;
                $display("FAIL run_fall_tc edge %0d: got %b expected %b", k, u_if.Enable, e);
            end else begin
                $display("[TB] run_fall_tc edge %0d en=%b ok", k, u_if.Enable);
            end
        end
    endtask

    task automatic test_async_reset();
        bit e;
        u_if.Speed = SPD_1HZ;
        u_if.Run   = 1'b1;
        // Count down to cnt=2 then reset between edges.
        for (int k = 0; k <= 1; k++) begin
            exp_q.push_back(1'b0);
            @(posedge Clock); #1;
            e = exp_q.pop_front();
            n_tests++;
            if (u_if.Enable !== e) begin
                n_fail++;
                $display("FAIL async_pre edge %0d: got %b expected %b", k, u_if.Enable, e);
            end
        end
        #2 Resetn = 1'b0;
        #1;
        n_tests++;
        if (u_if.Enable !== 1'b0) begin
            n_fail++;
            $display("FAIL async_mid_count: got %b expected 0", u_if.Enable);
        end
        @(posedge Clock); #1;
        Resetn = 1'b1;
        for (int k = 0; k <= 11; k++) begin
            u_if.Speed = (k < 9) ? SPD_1HZ : SPD_FAST;
            exp_q.push_back((k == 4) || (k == 8) || (k >= 10));
            @(posedge Clock); #1;
            e = exp_q.pop_front();
            n_tests++;
            if (u_if.Enable !== e) begin
                n_fail++;
                $display("FAIL async_post edge %0d: got %b expected %b", k, u_if.Enable, e);
            end else begin
                $display("[TB] async_post edge %0d en=%b ok", k, u_if.Enable);
            end
        end
        // Enable is high here; an asynchronous reset must clear it before any edge.
        #1 Resetn = 1'b0;
        #1;
        n_tests++;
        if (u_if.Enable !== 1'b0) begin
            n_fail++;
            $display("FAIL async_while_high: got %b expected 0", u_if.Enable);
        end
        @(posedge Clock); #1;
        Resetn   = 1'b1;
        u_if.Run = 1'b0;
        exp_q.push_back(1'b0);
        @(posedge Clock); #1;
        e = exp_q.pop_front();
        n_tests++;
        if (u_if.Enable !== e) begin
            n_fail++;
            $display("FAIL async_idle: got %b expected %b", u_if.Enable, e);
        end
    endtask

`ifdef RATE_GEN_STEP_EN
    task automatic test_step();
        bit e;
        u_if.Run   = 1'b0;
        u_if.Speed = SPD_1HZ;
        for (int k = 0; k <= 6; k++) begin
            u_if.Step = (k <= 4);
            exp_q.push_back(k == 0);
            @(posedge Clock); #1;
            e = exp_q.pop_front();
            n_tests++;
            if (u_if.Enable !== e) begin
                n_fail++;
                $display("FAIL step_idle edge %0d: got %b expected %b", k, u_if.Enable, e);
            end else begin
                $display("[TB] step_idle edge %0d en=%b ok", k, u_if.Enable);
            end
        end
        for (int k = 0; k <= 10; k++) begin
            u_if.Run  = (k < 10);
            u_if.Step = (k >= 2) && (k <= 6);
            exp_q.push_back((k == 4) || (k == 8));
            @(posedge Clock); #1;
            e = exp_q.pop_front();
            n_tests++;
            if (u_if.Enable !== e) begin
                n_fail++;
                $display("FAIL step_run edge %0d: got %b expected %b", k, u_if.Enable, e);
            end else begin
                $display("[TB] step_run edge %0d en=%b ok", k, u_if.Enable);
            end
        end
    endtask
`endif

    initial begin
        n_tests = 0;
        n_fail  = 0;
        test_reset();
        test_rate_1hz();
        test_fast();
        test_speed_change();
        test_run_fall_at_tc();
        test_async_reset();
`ifdef RATE_GEN_STEP_EN
        test_step();
`endif
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/rate_enable_gen.md
# rate_enable_gen

Programmable rate divider that generates the single-cycle `Enable` pulse consumed by the 8-bit T-flip-flop counter stage. It sits directly upstream of that counter, shares its clock, and converts a board-level run switch and 2-bit speed select into a counting cadence: every cycle, 1 Hz, 0.5 Hz or 0.25 Hz at the nominal clock. Output is registered and glitch-free, so the counter increments exactly once per pulse.

## Interface
- `CLK_HZ`, 50_000_000, clock cycles per second; must be ≥ 1.
- `CNT_W`, 28, down-counter width; must satisfy 2^CNT_W > 4*CLK_HZ-1.

Ports:
- `Clock`  in  1  sole clock, rising edge.
- `Resetn`  in  1  asynchronous, active-low reset.
- `Run`  in  1  level; 1 = generate pulses, 0 = idle.
- `Speed`  in  2  rate select: 00 every cycle, 01 1 Hz, 10 0.5 Hz, 11 0.25 Hz.
- `Step`  in  1  single-step request; present only with `RATE_GEN_STEP_EN`.
- `Enable`  out  1  registered one-cycle pulse to the counter.

## Operation
- Reload value R(Speed): 00→0, 01→CLK_HZ-1, 10→2*CLK_HZ-1, 11→4*CLK_HZ-1. Pulse period in RUN = R+1 cycles.
- State machine, two states:
  - IDLE: `Enable`=0 and counter held. If `Run`=1 at an edge: go to RUN, cnt←R(Speed), spd_q←Speed.
  - RUN: if `Run`=0 at an edge: go to IDLE, `Enable`←0. Otherwise, if Speed≠spd_q: cnt←R(Speed), spd_q←Speed, `Enable`←0 (phase restart, no pulse). Otherwise, if cnt=0: `Enable`←1, cnt←R(spd_q). Otherwise: `Enable`←0, cnt←cnt-1.
- Priority in RUN: Run deassert > speed change > terminal count.
- Arithmetic: unsigned, CNT_W bits. cnt never underflows because reload occurs at 0.
- `Enable` is never high for two consecutive cycles unless R=0.

## Timing
- Reset (async assert, any time, including mid-count): state=IDLE, cnt=0, spd_q=00, `Enable`=0 immediately. Step edge register=0.
- Release of `Resetn` is synchronous to the next edge in effect; first edge after release evaluates IDLE.
- Run sampled 1 at edge k: first `Enable` high after edge k+R+1, then every R+1 cycles.
- Speed=00: `Enable` high continuously from edge k+1 until Run falls.
- Run sampled 0 at edge j: `Enable` low after edge j, even if the terminal count coincides.
- Speed change at edge j: next pulse after edge j+R_new+1.
- Latency from any input to `Enable`: one edge (registered); no combinational paths to the output.

## Configuration
- `RATE_GEN_STEP_EN` defined: adds the `Step` port plus a one-flop edge detector. In IDLE, a 0→1 transition of `Step` sampled at edge j drives `Enable` high for exactly the cycle after edge j. `Step` is ignored in RUN, and a held `Step` yields one pulse only.
- Undefined: no `Step` port and no edge-detector flop. `Enable` is driven solely by the RUN state.

## Structure
- Shared package `rate_gen_pkg`: state enum {IDLE, RUN}, speed code constants (SPD_FAST, SPD_1HZ, SPD_HALF, SPD_QUARTER), and function `reload_of(speed, clk_hz)` returning the CNT_W-bit R.
- No sub-module. Divider, FSM and optional step detector stay in one module.

## Test plan
Bench uses CLK_HZ=4, CNT_W=5, so R = 0/3/7/15.
- Reset, then Run=1, Speed=01 at edge 0 → `Enable` high after edges 4, 8, 12, low elsewhere.
- Speed=00, Run=1 for 6 edges → `Enable` high for 5 consecutive cycles starting after edge 1, low after Run falls.
- Speed=11 running, switch to 10 at edge 5 → no pulse before edge 13, pulse after edge 13, then every 8 cycles.
- Run falls on the edge where cnt=0 → no pulse, state=IDLE. Run re-raised → full R+1 wait before the first pulse.
- `Resetn` pulsed low mid-count (cnt=2, Speed=01) → `Enable`=0 at once. After release with Run=1, first pulse comes R+1 edges after the first RUN entry.
- With `RATE_GEN_STEP_EN`, IDLE, `Step` held high 5 cycles → exactly one `Enable` pulse. The same stimulus in RUN → pulse train unchanged.
